// File: rtl/ceespu_writeback_if.sv
// Execute/memory-to-writeback bundle: instruction handoff, data-memory response,
// register file write port and decode bypass.
interface ceespu_writeback_if;
    logic        I_valid;
    logic        O_ready;
    logic [4:0]  I_rd;
    logic        I_wen;
    logic [31:0] I_result;
    logic        I_is_load;
    logic [1:0]  I_load_size;
    logic        I_load_signed;
    logic [1:0]  I_addr_lo;
    logic        I_mem_valid;
    logic [31:0] I_mem_data;
    logic        O_we;
    logic [4:0]  O_selD;
    logic [31:0] O_dataD;
    logic        O_fwd_valid;
    logic [4:0]  O_fwd_sel;
    logic [31:0] O_fwd_data;
    logic        O_err;

    modport master (
        output I_valid, I_rd, I_wen, I_result, I_is_load, I_load_size,
               I_load_signed, I_addr_lo, I_mem_valid, I_mem_data,
        input  O_ready, O_we, O_selD, O_dataD, O_fwd_valid, O_fwd_sel,
               O_fwd_data, O_err
    );

    modport slave (
        input  I_valid, I_rd, I_wen, I_result, I_is_load, I_load_size,
               I_load_signed, I_addr_lo, I_mem_valid, I_mem_data,
        output O_ready, O_we, O_selD, O_dataD, O_fwd_valid, O_fwd_sel,
               O_fwd_data, O_err
    );
endinterface

// File: rtl/ceespu_writeback.sv
// ceespu writeback stage: load wait/align/extend, one registered RF write per instruction.
// Define CEESPU_WB_FWD_EN to drive the same-cycle bypass; otherwise O_fwd_* are tied to 0.
//
// state      | meaning
// S_IDLE     | ready for an instruction; non-loads commit directly
// S_WAIT_MEM | load accepted, waiting for data-memory response or timeout
module ceespu_writeback #(
    parameter int TIMEOUT = 255
) (
    input  logic I_clk,
    input  logic I_rst,
    ceespu_writeback_if.slave wb
);
    typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [4:0]    rd_q, rd_d;
    logic          wen_q, wen_d;
    logic [1:0]    size_q, size_d;
    logic          sgn_q, sgn_d;
    logic [1:0]    alo_q, alo_d;
    logic          we_q, we_d;
    logic [4:0]    sel_q, sel_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;

    logic          ready;
    logic          accept;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   aligned;

    // Ready depends only on state and reset so upstream never sees a loop through I_valid.
    assign ready  = (state_q == S_IDLE) & ~I_rst;
    assign accept = wb.I_valid & ready;
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        case (alo_q)
            2'd0:    byte_sel = wb.I_mem_data[7:0];
            2'd1:    byte_sel = wb.I_mem_data[15:8];
            2'd2:    byte_sel = wb.I_mem_data[23:16];
            default: byte_sel = wb.I_mem_data[31:24];
        endcase
        half_sel = alo_q[1] ? wb.I_mem_data[31:16] : wb.I_mem_data[15:0];
        case (size_q)
            2'b00:   aligned = {{24{sgn_q & byte_sel[7]}}, byte_sel};
            2'b01:   aligned = {{16{sgn_q & half_sel[15]}}, half_sel};
            default: aligned = wb.I_mem_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        alo_d   = alo_q;
        we_d    = 1'b0;
        sel_d   = sel_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (wb.I_is_load) begin
                        rd_d    = wb.I_rd;
                        wen_d   = wb.I_wen;
                        size_d  = wb.I_load_size;
                        sgn_d   = wb.I_load_signed;
                        alo_d   = wb.I_addr_lo;
                        cnt_d   = '0;
                        state_d = S_WAIT_MEM;
                    end else begin
                        we_d   = wb.I_wen;
                        sel_d  = wb.I_rd;
                        data_d = wb.I_result;
                    end
                end
            end
            S_WAIT_MEM: begin
                // A response arriving on the timeout cycle still wins.
                if (wb.I_mem_valid) begin
                    we_d    = wen_q;
                    sel_d   = rd_q;
                    data_d  = aligned;
                    state_d = S_IDLE;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            alo_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            alo_q   <= alo_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign wb.O_ready = ready;
    assign wb.O_we    = we_q;
    assign wb.O_selD  = sel_q;
    assign wb.O_dataD = data_q;
    assign wb.O_err   = err_q;

`ifdef CEESPU_WB_FWD_EN
    assign wb.O_fwd_valid = we_q;
    assign wb.O_fwd_sel   = sel_q;
    assign wb.O_fwd_data  = data_q;
`else
    assign wb.O_fwd_valid = 1'b0;
    assign wb.O_fwd_sel   = '0;
    assign wb.O_fwd_data  = '0;
`endif
endmodule
